// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Two-port arbiter in front of a single-port data RAM. Port A is the CPU
//   datapath and port B the program loader / debug path. Each granted
//   request gets exactly one RAM cycle (ACCESS) followed by a one-cycle
//   completion pulse (RESP). Ties are broken round-robin, with A favoured
//   after reset.
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata          port A request, write flag, addr, data
//   a_ack/a_rdata                      port A completion pulse, read data
//   b_req/b_we/b_addr/b_wdata          port B request (same meaning as A)
//   b_ack/b_rdata                      port B completion pulse, read data
//   ram_cs/ram_memRead/ram_memWrite    RAM strobes, high only in ACCESS
//   ram_address/ram_writeData          RAM address / write data (held)
//   ram_readData                       RAM read data, sampled leaving ACCESS
//   busy                               high while not IDLE
//   gnt_id                             owner of the current access (0=A, 1=B)
//
// Handshake: a requester raises req with we/addr/wdata stable and keeps
// them stable until it sees ack (a single-cycle pulse). It drops req in the
// cycle after ack. Nothing is queued: a req that drops before it is granted
// is simply forgotten. The just-acked port's req is ignored in RESP so a
// port is never served twice in a row while the other one is waiting.

module data_ram_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [9:0]  a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_ack,
  output logic [63:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [9:0]  b_addr,
  input  logic [63:0] b_wdata,
  output logic        b_ack,
  output logic [63:0] b_rdata,
  output logic        ram_cs,
  output logic        ram_memRead,
  output logic        ram_memWrite,
  output logic [9:0]  ram_address,
  output logic [63:0] ram_writeData,
  input  logic [63:0] ram_readData,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic        gntId;      // owner of the latched access
  logic        lastGnt;    // port granted most recently; the other wins ties
  logic        weLat;      // latched write flag of the current access

  logic        grantValid; // a new access is latched at this edge
  logic        grantId;    // which port it belongs to
  logic        winWe;
  logic [9:0]  winAddr;
  logic [63:0] winWdata;

  // Next-state and arbitration
  always_comb begin
    stateNext  = state;
    grantValid = 1'b0;
    grantId    = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          grantValid = 1'b1;
          grantId    = ~lastGnt;
        end else if (a_req) begin
          grantValid = 1'b1;
          grantId    = 1'b0;
        end else if (b_req) begin
          grantValid = 1'b1;
          grantId    = 1'b1;
        end
        stateNext = grantValid ? ACCESS : IDLE;
      end
      ACCESS: begin
        stateNext = RESP;
      end
      RESP: begin
        // Only the other port may chain directly into ACCESS; the acked
        // port still shows req this cycle and must not be re-served.
        if (gntId ? a_req : b_req) begin
          grantValid = 1'b1;
          grantId    = ~gntId;
          stateNext  = ACCESS;
        end else begin
          stateNext  = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Winner's request fields
  always_comb begin
    winWe    = grantId ? b_we    : a_we;
    winAddr  = grantId ? b_addr  : a_addr;
    winWdata = grantId ? b_wdata : a_wdata;
  end

  // State, latched request and read-data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      gntId         <= 1'b0;
      lastGnt       <= 1'b1;  // B "granted last" so A wins the first tie
      weLat         <= 1'b0;
      ram_address   <= 10'd0;
      ram_writeData <= 64'd0;
      a_rdata       <= 64'd0;
      b_rdata       <= 64'd0;
    end else begin
      state <= stateNext;
      if (grantValid) begin
        gntId       <= grantId;
        lastGnt     <= grantId;
        weLat       <= winWe;
        ram_address <= winAddr;
        // Write data only moves for writes, so reads leave it untouched.
        if (winWe) begin
          ram_writeData <= winWdata;
        end
      end
      if (state == ACCESS && !weLat) begin
        if (gntId) begin
          b_rdata <= ram_readData;
        end else begin
          a_rdata <= ram_readData;
        end
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    ram_cs       = (state == ACCESS);
    ram_memRead  = (state == ACCESS) && !weLat;
    ram_memWrite = (state == ACCESS) && weLat;
    a_ack        = (state == RESP) && !gntId;
    b_ack        = (state == RESP) && gntId;
    busy         = (state != IDLE);
    gnt_id       = gntId;
  end

endmodule
